spi_host: RTL and testbench

//  SPI mode-0 master (CPOL=0, CPHA=0, MSB first) driving the spi_client port of MARLANN.

---
 rtl/spi_host_pkg.sv | 13 +
 rtl/spi_clk_div.sv | 20 ++
 rtl/spi_host.sv | 106 ++++++++++
 tb/tb_spi_host.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_host_pkg.sv
// Shared definitions for the SPI mode-0 host: FSM states and byte/half-period geometry.
package spi_host_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam int BYTE_W       = 8;
  localparam int HALF_PERIODS = 16;
endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: half_tick on the last cycle of every CLK_DIV-cycle window while en is high.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic i_spi_clk,
  input  logic i_reset,
  input  logic en,
  output logic half_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign half_tick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge i_spi_clk) begin
    if (i_reset || !en || half_tick) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/spi_host.sv
// SPI mode-0 master (CPOL=0, CPHA=0, MSB first) with a byte valid/ready host interface.
// Define SPI_HOST_LOOPBACK_EN to sample o_mosi instead of i_miso (rx byte echoes tx byte).
module spi_host
  import spi_host_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 3
) (
  input  logic       i_spi_clk,
  input  logic       i_reset,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_last,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_busy,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic       o_mosi,
  input  logic       i_miso
);
  localparam int GW = $clog2(CLK_DIV + CS_GAP);

  state_t            state, state_nxt;
  logic [3:0]        h;
  logic [BYTE_W-1:0] tx_sr, rx_sr;
  logic              last_q;
  logic [GW-1:0]     gap_cnt;
  logic              half_tick, accept, miso_bit, byte_end;

`ifdef SPI_HOST_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = i_miso;
  assign miso_bit    = o_mosi;
`else
  assign miso_bit = i_miso;
`endif

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .i_spi_clk (i_spi_clk),
    .i_reset   (i_reset),
    .en        (state == ST_SETUP || state == ST_XFER),
    .half_tick (half_tick)
  );

  assign o_tx_ready = (state == ST_IDLE) || (state == ST_HOLD);
  assign accept     = i_tx_valid && o_tx_ready;
  assign byte_end   = (state == ST_XFER) && half_tick && (h == 4'(HALF_PERIODS - 1));
  assign o_busy     = (state != ST_IDLE);
  assign o_sclk     = (state == ST_XFER) && h[0];
  // CS stays low through the first CLK_DIV cycles of GAP as hold time after the last edge.
  assign o_cs_n     = !((state == ST_SETUP) || (state == ST_XFER) || (state == ST_HOLD) ||
                        ((state == ST_GAP) && (gap_cnt < GW'(CLK_DIV))));

  always_ff @(posedge i_spi_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_HOLD: if (accept)    state_nxt = ST_SETUP;
      ST_SETUP:         if (half_tick) state_nxt = ST_XFER;
      ST_XFER:          if (byte_end)  state_nxt = last_q ? ST_GAP : ST_HOLD;
      ST_GAP:           if (gap_cnt == GW'(CLK_DIV + CS_GAP - 1)) state_nxt = ST_IDLE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_spi_clk) begin
    if (i_reset) begin
      h          <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      last_q     <= 1'b0;
      gap_cnt    <= '0;
      o_mosi     <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      o_rx_valid <= 1'b0;
      gap_cnt    <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
      if (accept) begin
        tx_sr  <= i_tx_data;
        o_mosi <= i_tx_data[BYTE_W-1];
        last_q <= i_tx_last;
        h      <= '0;
      end
      if (state == ST_XFER && half_tick) begin
        h <= h + 1'b1;
        // Even->odd is the SCLK rising edge (sample); odd->even is falling (shift out).
        if (!h[0]) begin
          rx_sr <= {rx_sr[BYTE_W-2:0], miso_bit};
        end else if (!byte_end) begin
          o_mosi <= tx_sr[BYTE_W-2];
          tx_sr  <= {tx_sr[BYTE_W-2:0], 1'b0};
        end else begin
          o_rx_data  <= rx_sr;
          o_rx_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_host.sv
// Directed bench for spi_host: timeline model of one byte/frame checked every cycle, plus literal checks.
module tb_spi_host;
  localparam int D = 2;
  localparam int G = 3;

  logic       spi_clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy, sclk, cs_n, mosi, miso;

  spi_host #(.CLK_DIV(D), .CS_GAP(G)) dut (
    .i_spi_clk (spi_clk),
    .i_reset   (rst),
    .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready),
    .i_tx_data (tx_data),
    .i_tx_last (tx_last),
    .o_rx_valid(rx_valid),
    .o_rx_data (rx_data),
    .o_busy    (busy),
    .o_sclk    (sclk),
    .o_cs_n    (cs_n),
    .o_mosi    (mosi),
    .i_miso    (miso)
  );

  always #5 spi_clk = ~spi_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge spi_clk) cyc <= cyc + 1;

  // Mode-0 slave: presents MSB first, advances on SCLK falling edge, restarts when CS is high.
  logic [7:0] slv_byte = 8'h00;
  int         slv_cnt = 0;
  logic       slv_prev = 1'b0;
  assign miso = slv_byte[3'(7 - (slv_cnt % 8))];
  always @(negedge spi_clk) begin
    if (cs_n) slv_cnt <= 0;
    else if (slv_prev && !sclk) slv_cnt <= slv_cnt + 1;
    slv_prev <= sclk;
  end

  // Model: one accept at relative cycle k=0; everything follows from k, the last flag and D/G.
  bit         chk_en = 0;
  bit         m_act = 0;
  bit         m_last = 0;
  int         k = 0;
  int         bitn = 0;
  logic [7:0] m_tx = '0;
  logic [7:0] m_rx_sr = '0;
  logic [7:0] m_rx_data = '0;
  logic [7:0] mosi_cap = '0;
  bit         prev_e_sclk = 0;
  int         pulses = 0;
  int         run = 0;
  int         last_run = 0;

  always @(negedge spi_clk) begin
    bit e_cs, e_sclk, e_rdy, e_busy, e_rv;
    e_cs = 1; e_sclk = 0; e_rdy = 1; e_busy = 0; e_rv = 0;
    if (m_act) begin
      if (k <= D) begin
        e_cs = 0; e_rdy = 0; e_busy = 1;
      end else if (k <= 17 * D) begin
        e_cs = 0; e_rdy = 0; e_busy = 1; e_sclk = ((k - D - 1) / D) % 2;
      end else if (!m_last) begin
        e_cs = 0; e_busy = 1; e_rv = (k == 17 * D + 1);
      end else if (k <= 18 * D + G) begin
        e_cs = (k > 18 * D); e_rdy = 0; e_busy = 1; e_rv = (k == 17 * D + 1);
      end
    end
    if (e_sclk && !prev_e_sclk) begin
      if (chk_en) check("mosi_at_rise", mosi, m_tx[3'(7 - bitn)]);
      m_rx_sr  = {m_rx_sr[6:0], miso};
      mosi_cap = {mosi_cap[6:0], mosi};
      bitn++;
    end
    prev_e_sclk = e_sclk;
    if (e_rv) m_rx_data = m_rx_sr;
    if (chk_en) begin
      check("cs_n", cs_n, e_cs);
      check("sclk", sclk, e_sclk);
      check("tx_ready", tx_ready, e_rdy);
      check("busy", busy, e_busy);
      check("rx_valid", rx_valid, e_rv);
      check("rx_data", rx_data, m_rx_data);
      if (rx_valid) pulses++;
      if (!cs_n) run++;
      else if (run > 0) begin last_run = run; run = 0; end
    end
    if (rst) begin
      m_act = 0; m_rx_data = '0; chk_en = 1; run = 0;
    end else if (tx_valid && e_rdy) begin
      m_act = 1; k = 1; m_last = tx_last; m_tx = tx_data; bitn = 0;
    end else if (m_act) begin
      k++;
      if (m_last && k > 18 * D + G) m_act = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge spi_clk); #1; end
  endtask

  // Offers a byte and returns one cycle after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l);
    bit acc;
    int guard;
    tx_valid = 1'b1; tx_data = d; tx_last = l;
    acc = 0; guard = 0;
    while (!acc && guard < 200) begin
      @(negedge spi_clk);
      acc = tx_ready;
      @(posedge spi_clk); #1;
      guard++;
    end
    tx_valid = 1'b0;
    n_cmp++;
    if (!acc) begin
      n_err++;
      $display("FAIL send_timeout: byte %0h not accepted within %0d cycles", d, guard);
    end
  endtask

  int t0, t1;

  initial begin
    step(3);
    rst = 1'b0;
    step(2);
    check("reset_cs_n", cs_n, 1'b1);
    check("reset_ready", tx_ready, 1'b1);
    check("reset_rx_data", rx_data, 8'h00);

    // single-byte frame
    slv_byte = 8'h3C; pulses = 0;
    send(8'hA5, 1'b1);
    step(50);
    check("a5_mosi_bits", mosi_cap, 8'hA5);
    check("a5_rx_data", rx_data, 8'h3C);
    check("a5_cs_low_len", last_run, 36);
    check("a5_pulses", pulses, 1);

    // two-byte frame, CS held across bytes
    slv_byte = 8'hC3; pulses = 0;
    send(8'h01, 1'b0);
    send(8'h80, 1'b1);
    step(50);
    check("two_cs_low_len", last_run, 71);
    check("two_pulses", pulses, 2);
    check("two_rx_data", rx_data, 8'hC3);
    check("two_mosi_last", mosi_cap, 8'h80);

    // byte offered throughout GAP is accepted in first IDLE cycle, exactly once
    slv_byte = 8'h6E; pulses = 0;
    send(8'h80, 1'b1);
    t0 = cyc;
    send(8'h11, 1'b1);
    t1 = cyc;
    check("gap_accept_delay", t1 - t0, 18 * D + G + 1);
    step(45);
    check("gap_pulses", pulses, 2);
    check("gap_mosi", mosi_cap, 8'h11);
    check("gap_rx_data", rx_data, 8'h6E);

    // reset during h=7 of 0xFF aborts the byte
    pulses = 0;
    send(8'hFF, 1'b1);
    step(16);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("abort_cs_n", cs_n, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", tx_ready, 1'b1);
    step(60);
    check("abort_pulses", pulses, 0);
    check("abort_rx_data", rx_data, 8'h00);

    // clean frame after abort
    slv_byte = 8'h96;
    send(8'h5A, 1'b1);
    step(50);
    check("post_mosi", mosi_cap, 8'h5A);
    check("post_rx_data", rx_data, 8'h96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
